// File: rtl/c10_tape_player.sv
// MC-10 .c10 cassette player: fetches image bytes from SDRAM and emits them LSB-first as FSK on data.
// Optional build macro TAPE_LEADER_EN prepends 128 synthetic 0x55 leader bytes after every rewind/reset.
module c10_tape_player #(
    parameter int HALF_1200 = 1667,
    parameter int HALF_2400 = 833,
    parameter int RD_LAT    = 4,
    parameter int AW        = 25
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          play,
    input  logic          rewind,
    input  logic [AW-1:0] tape_len,
    output logic [AW-1:0] sdram_addr,
    output logic          sdram_rd,
    input  logic [7:0]    sdram_data,
    output logic          data,
    output logic [2:0]    status
);

    localparam int HMAX = (HALF_1200 > HALF_2400) ? HALF_1200 : HALF_2400;
    localparam int CW   = $clog2(HMAX);
    localparam int WCW  = $clog2(RD_LAT + 1);

    // status encodings {eot, playing, fetching}
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_FETCH = 3'b011;
    localparam logic [2:0] ST_PLAY  = 3'b010;
    localparam logic [2:0] ST_EOT   = 3'b100;

    typedef enum logic [2:0] {
        PAUSED,
        FETCH,
        WAIT,
        SHIFT,
        EOT
`ifdef TAPE_LEADER_EN
        , LEADER
`endif
    } state_t;

    logic [1:0] btn_in;
    logic [1:0] btn_edge;
    logic       play_edge;
    logic       rewind_edge;

    assign btn_in = {rewind, play};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic cur_reg;
            logic prev_reg;
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    cur_reg  <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    cur_reg  <= btn_in[gi];
                    prev_reg <= cur_reg;
                end
            end
            assign btn_edge[gi] = cur_reg & ~prev_reg;
        end
    endgenerate

    assign play_edge   = btn_edge[0];
    assign rewind_edge = btn_edge[1];

    state_t          state_reg;
    logic [AW-1:0]   ptr_reg;
    logic [AW-1:0]   tape_len_reg;
    logic [7:0]      shreg_reg;
    logic [2:0]      idx_reg;
    logic [CW-1:0]   half_cnt_reg;
    logic            phase_reg;
    logic [WCW-1:0]  wait_cnt_reg;
    logic            rd_busy_reg;
    logic            resume_reg;
    logic            data_reg;
    logic            sdram_rd_reg;
    logic [AW-1:0]   sdram_addr_reg;
    logic [2:0]      status_reg;
    logic [CW-1:0]   half_m1;
`ifdef TAPE_LEADER_EN
    localparam int LEADER_BYTES = 128;
    logic [7:0]      lead_cnt_reg;
    logic            in_lead_reg;
`endif

    assign half_m1    = shreg_reg[idx_reg] ? CW'(HALF_2400 - 1) : CW'(HALF_1200 - 1);
    assign data       = data_reg;
    assign sdram_rd   = sdram_rd_reg;
    assign sdram_addr = sdram_addr_reg;
    assign status     = status_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= PAUSED;
            ptr_reg        <= '0;
            tape_len_reg   <= tape_len;
            shreg_reg      <= 8'h00;
            idx_reg        <= 3'd0;
            half_cnt_reg   <= '0;
            phase_reg      <= 1'b0;
            wait_cnt_reg   <= '0;
            rd_busy_reg    <= 1'b0;
            resume_reg     <= 1'b0;
            data_reg       <= 1'b0;
            sdram_rd_reg   <= 1'b0;
            sdram_addr_reg <= '0;
            status_reg     <= ST_IDLE;
`ifdef TAPE_LEADER_EN
            lead_cnt_reg   <= 8'd0;
            in_lead_reg    <= 1'b0;
`endif
        end else begin
            sdram_rd_reg <= 1'b0;

            // An issued read always completes, even if playback paused meanwhile.
            if (rd_busy_reg) begin
                if (wait_cnt_reg == WCW'(RD_LAT)) begin
                    rd_busy_reg <= 1'b0;
                    ptr_reg     <= ptr_reg + AW'(1);
                    shreg_reg   <= sdram_data;
                end else begin
                    wait_cnt_reg <= wait_cnt_reg + WCW'(1);
                end
            end

            if (rewind_edge) begin
                state_reg    <= PAUSED;
                ptr_reg      <= '0;
                tape_len_reg <= tape_len;
                rd_busy_reg  <= 1'b0;
                resume_reg   <= 1'b0;
                data_reg     <= 1'b0;
                status_reg   <= ST_IDLE;
`ifdef TAPE_LEADER_EN
                lead_cnt_reg <= 8'd0;
                in_lead_reg  <= 1'b0;
`endif
            end else if (play_edge && state_reg != PAUSED && state_reg != EOT) begin
                state_reg  <= PAUSED;
                data_reg   <= 1'b0;
                status_reg <= ST_IDLE;
                resume_reg <= 1'b0;
            end else begin
                case (state_reg)
                    PAUSED: begin
                        // A play edge during a completing read is deferred until ptr settles.
                        if (rd_busy_reg) begin
                            if (play_edge) begin
                                resume_reg <= ~resume_reg;
                            end
                        end else begin
                            resume_reg <= 1'b0;
                            if (play_edge ^ resume_reg) begin
                                if (ptr_reg >= tape_len_reg) begin
                                    state_reg  <= EOT;
                                    status_reg <= ST_EOT;
                                end
`ifdef TAPE_LEADER_EN
                                else if (lead_cnt_reg != 8'(LEADER_BYTES)) begin
                                    state_reg  <= LEADER;
                                    status_reg <= ST_PLAY;
                                end
`endif
                                else begin
                                    state_reg      <= FETCH;
                                    status_reg     <= ST_FETCH;
                                    sdram_rd_reg   <= 1'b1;
                                    sdram_addr_reg <= ptr_reg;
                                    rd_busy_reg    <= 1'b1;
                                    wait_cnt_reg   <= '0;
                                end
                            end
                        end
                    end
                    FETCH: begin
                        state_reg <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt_reg == WCW'(RD_LAT)) begin
                            state_reg    <= SHIFT;
                            status_reg   <= ST_PLAY;
                            idx_reg      <= 3'd0;
                            half_cnt_reg <= '0;
                            phase_reg    <= 1'b0;
                            data_reg     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (half_cnt_reg == half_m1) begin
                            half_cnt_reg <= '0;
                            if (!phase_reg) begin
                                phase_reg <= 1'b1;
                                data_reg  <= 1'b0;
                            end else if (idx_reg != 3'd7) begin
                                idx_reg   <= idx_reg + 3'd1;
                                phase_reg <= 1'b0;
                                data_reg  <= 1'b1;
                            end else begin
`ifdef TAPE_LEADER_EN
                                if (in_lead_reg) begin
                                    in_lead_reg  <= 1'b0;
                                    lead_cnt_reg <= lead_cnt_reg + 8'd1;
                                    if (lead_cnt_reg == 8'(LEADER_BYTES - 1)) begin
                                        state_reg      <= FETCH;
                                        status_reg     <= ST_FETCH;
                                        sdram_rd_reg   <= 1'b1;
                                        sdram_addr_reg <= ptr_reg;
                                        rd_busy_reg    <= 1'b1;
                                        wait_cnt_reg   <= '0;
                                    end else begin
                                        state_reg <= LEADER;
                                    end
                                end else
`endif
                                if (ptr_reg == tape_len_reg) begin
                                    state_reg  <= EOT;
                                    status_reg <= ST_EOT;
                                end else begin
                                    state_reg      <= FETCH;
                                    status_reg     <= ST_FETCH;
                                    sdram_rd_reg   <= 1'b1;
                                    sdram_addr_reg <= ptr_reg;
                                    rd_busy_reg    <= 1'b1;
                                    wait_cnt_reg   <= '0;
                                end
                            end
                        end else begin
                            half_cnt_reg <= half_cnt_reg + CW'(1);
                        end
                    end
`ifdef TAPE_LEADER_EN
                    LEADER: begin
                        shreg_reg    <= 8'h55;
                        in_lead_reg  <= 1'b1;
                        state_reg    <= SHIFT;
                        idx_reg      <= 3'd0;
                        half_cnt_reg <= '0;
                        phase_reg    <= 1'b0;
                        data_reg     <= 1'b1;
                    end
`endif
                    EOT: begin
                    end
                    default: begin
                        state_reg  <= PAUSED;
                        status_reg <= ST_IDLE;
                        data_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/c10_tape_player.md
Name: c10_tape_player

Overview:
- Plays a .c10 cassette image stored in SDRAM.
- Fetches bytes sequentially over a single-issue, fixed-latency SDRAM read port.
- Serialises each byte LSB-first into the MC-10 FSK waveform: bit 0 is one 1200 Hz cycle, bit 1 is one 2400 Hz cycle.
- Sits between the SDRAM controller and the mc10 cassette input (cin); also drives the 3-bit tape status consumed by the overlay.

Parameters:
- HALF_1200, 1667, clk_sys cycles per half-period of a 0 bit (4 MHz clock).
- HALF_2400, 833, clk_sys cycles per half-period of a 1 bit.
- RD_LAT, 4, cycles from sdram_rd pulse to sdram_data valid.
- AW, 25, SDRAM byte address width.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- play  in  1  level from OSD; each rising edge toggles play/pause.
- rewind  in  1  level from OSD; each rising edge rewinds.
- tape_len  in  AW  image length in bytes; sampled on every rewind and on reset.
- sdram_addr  out  AW  byte address of the current fetch.
- sdram_rd  out  1  one-cycle read strobe.
- sdram_data  in  8  read data, valid exactly RD_LAT cycles after sdram_rd.
- data  out  1  FSK tape bit to mc10 cin.
- status  out  3  {eot, playing, fetching}.

Behaviour:
- Reset values: data=0, sdram_rd=0, sdram_addr=0, status=3'b000, state=PAUSED, internal byte pointer=0, edge detectors cleared.
- play and rewind are registered once; a rising edge is prev==0 && cur==1.
- States: PAUSED, FETCH, WAIT, SHIFT, EOT.
- PAUSED:
  - data=0.
  - Play edge: if ptr>=tape_len go to EOT, else go to FETCH.
- FETCH:
  - Drive sdram_addr=ptr and sdram_rd=1 for exactly one cycle, then go to WAIT.
  - Status fetching=1 from FETCH through WAIT.
- WAIT:
  - Count RD_LAT cycles, latch sdram_data into shift reg, ptr<=ptr+1, bit index=0, go to SHIFT.
  - sdram_addr holds its value until the next FETCH.
- SHIFT:
  - Current bit b=shreg[idx]; half=b?HALF_2400:HALF_1200.
  - data=1 for half cycles, then data=0 for half cycles.
  - After 8 bits: if ptr==tape_len go to EOT, else go to FETCH.
  - The FETCH/WAIT gap between bytes (1+RD_LAT cycles) holds data=0 and is an accepted timing error.
- EOT:
  - data=0, eot=1.
  - Only rewind leaves EOT.
- playing=1 in FETCH/WAIT/SHIFT.
- Play edge while running:
  - Enter PAUSED immediately; data forced to 0.
  - The in-progress byte is discarded; ptr is not decremented, so that byte is skipped on resume.
  - Exception: if the pause lands in WAIT, the read is allowed to complete and ptr still increments.
- Rewind edge in any state:
  - ptr<=0, eot<=0, re-sample tape_len, go to PAUSED.
  - Rewind wins over a simultaneous play edge.
- tape_len==0: play edge goes directly to EOT with no SDRAM access.
- ptr width is AW; a tape_len of all-ones never wraps because the check happens before the fetch.
- Reset mid-SHIFT: next cycle data=0 and all registers return to their reset values.

Optional Feature:
- Macro: TAPE_LEADER_EN.
- When defined:
  - After every rewind or reset, the first play inserts 128 synthetic 0x55 bytes (state LEADER) before fetching address 0.
  - No SDRAM reads occur during the leader.
  - A pause during the leader keeps the leader count.
  - status fetching=0 during the leader.
- When undefined: playback starts at address 0 with no leader.

Test Plan:
- Reset, then play edge with tape_len=2, SDRAM[0]=0x01, SDRAM[1]=0x00:
  - sdram_rd pulses with addr 0.
  - Byte 0 emits first a 833/833 high/low cycle (bit 1), then seven 1667/1667 cycles.
  - Byte 1 emits eight 1667/1667 cycles.
  - status then equals 3'b100 and data=0.
- Pause mid-byte 0 with tape_len=3:
  - data drops to 0 within 1 cycle; no further sdram_rd.
  - Next play edge fetches addr 1.
- Rewind while in EOT: status=000, next play edge fetches addr 0.
- tape_len=0, play edge: no sdram_rd ever; status=100 after 2 cycles.
- Play and rewind rising on the same cycle during SHIFT: result is PAUSED with ptr=0.
- Timing check: the sdram_rd to shift-reg load delay equals RD_LAT=4.
- With TAPE_LEADER_EN defined and tape_len=1:
  - 128×8 bit-cycles of the 0x55 pattern appear before the first sdram_rd.
  - The first sdram_rd fetches addr 0.
